// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CHECKED} state_t;

  // Expected y indexed by {a,b}; bit 3 is a=1,b=1.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_resp_checker_stable_detect.sv
// Tracks the applied {a,b} pattern and counts how long it has been stable.
module stable_detect #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic run,
  input  logic zero,
  output logic changed,
  output logic stable_hit
);

  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  logic [1:0] ab_q;
  logic [7:0] cnt;

  assign changed    = ({a, b} != ab_q);
  assign stable_hit = !changed && (cnt == LAST);

  // The count parks at LAST so a held pattern is sampled only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q <= 2'b00;
      cnt  <= 8'd0;
    end else begin
      ab_q <= {a, b};
      if (zero || changed)
        cnt <= 8'd0;
      else if (run && (cnt != LAST))
        cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gate_resp_checker.sv
// Response monitor for 2-input gate DUTs: waits for each {a,b} pattern to
// settle, checks y against TRUTH, and accumulates coverage and mismatches.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_AND,
  parameter int         SETTLE = 4,
  parameter int         CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          a,
  input  logic          b,
  input  logic          y,
  output logic [3:0]    cov,
  output logic [CW-1:0] err_cnt,
  output logic          mismatch,
  output logic [1:0]    last_idx,
  output logic          done,
  output logic          pass
);

  state_t     state_q, state_d;
  logic       changed, stable_hit;
  logic       sample;
  logic       cnt_zero, cnt_run;
  logic [1:0] ab;

  assign ab       = {a, b};
  assign cnt_zero = clr || !en || (state_q == IDLE);
  assign cnt_run  = (state_q == WAIT);

  stable_detect #(.SETTLE(SETTLE)) u_stable (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .run        (cnt_run),
    .zero       (cnt_zero),
    .changed    (changed),
    .stable_hit (stable_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // clr and en outrank any pending sample.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    if (clr) begin
      state_d = en ? WAIT : IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WAIT;
        WAIT: begin
          if (stable_hit) begin
            sample  = 1'b1;
            state_d = CHECKED;
          end
        end
        CHECKED: if (changed) state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // done/pass follow cov/err_cnt by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov      <= 4'b0000;
      err_cnt  <= '0;
      mismatch <= 1'b0;
      last_idx <= 2'b00;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else if (clr) begin
      cov      <= 4'b0000;
      err_cnt  <= '0;
      mismatch <= 1'b0;
      last_idx <= 2'b00;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      done     <= &cov;
      pass     <= (&cov) && (err_cnt == '0);
      if (sample) begin
        cov[ab]  <= 1'b1;
        last_idx <= ab;
        if (y != TRUTH[ab]) begin
          mismatch <= 1'b1;
          if (err_cnt != {CW{1'b1}})
            err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker with a mismatch-pulse scoreboard.
module tb_gate_resp_checker;
  import gate_chk_pkg::*;

  localparam int SETTLE = 4;

  logic       clk, rst_n, en, clr, a, b, y;
  logic [3:0] cov, cov2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic       mismatch, mismatch2, done, done2, pass, pass2;
  logic [1:0] last_idx, last_idx2;

  typedef struct {
    int         cyc;
    logic [1:0] idx;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         mm2_cnt = 0;
  logic [1:0] prev_ab = 2'b00;
  logic [3:0] tt_model;

  gate_resp_checker #(.TRUTH(TT_AND), .SETTLE(SETTLE), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .y(y),
    .cov(cov), .err_cnt(err_cnt), .mismatch(mismatch), .last_idx(last_idx),
    .done(done), .pass(pass)
  );

  gate_resp_checker #(.TRUTH(TT_AND), .SETTLE(SETTLE), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .y(y),
    .cov(cov2), .err_cnt(err_cnt2), .mismatch(mismatch2), .last_idx(last_idx2),
    .done(done2), .pass(pass2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every mismatch pulse must match the oldest predicted one in edge and index.
  always @(negedge clk) begin
    if (mismatch2) mm2_cnt <= mm2_cnt + 1;
    if (mismatch) begin
      checks = checks + 1;
      if (sbq.size() == 0) begin
        errors = errors + 1;
        $error("[TB] FAIL sb_unexpected_pulse observed idx=%0d cyc=%0d expected no pulse", last_idx, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        assert (cyc === e.cyc && last_idx === e.idx) else begin
          errors = errors + 1;
          $error("[TB] FAIL sb_pulse observed cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cyc, last_idx, e.cyc, e.idx);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic holdFor(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; a new pattern held SETTLE+1 edges gets sampled.
  task automatic applyStimulus(input logic [1:0] ab, input logic yv, input int hold);
    exp_t e;
    a = ab[1];
    b = ab[0];
    y = yv;
    if (ab != prev_ab && hold >= SETTLE + 1 && yv !== tt_model[ab]) begin
      e.cyc = cyc + SETTLE + 1;
      e.idx = ab;
      sbq.push_back(e);
    end
    prev_ab = ab;
    holdFor(hold);
  endtask

  task automatic doClear();
    clr = 1'b1;
    holdFor(1);
    clr = 1'b0;
    mm2_cnt = 0;
  endtask

  initial begin
    tt_model = TT_AND;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    holdFor(2);
    checkOutput("rst_cov", cov, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_done_pass", {done, pass, mismatch, last_idx}, 0);
    rst_n = 1'b1;
    en = 1'b1;

    // AND DUT, all four patterns.
    applyStimulus(2'b00, 1'b0, 100);
    applyStimulus(2'b01, 1'b0, 100);
    applyStimulus(2'b10, 1'b0, 100);
    applyStimulus(2'b11, 1'b1, SETTLE + 1);
    checkOutput("and_cov", cov, 4'b1111);
    checkOutput("and_done_lag", done, 0);
    holdFor(1);
    checkOutput("and_done", done, 1);
    checkOutput("and_pass", pass, 1);
    checkOutput("and_err", err_cnt, 0);
    holdFor(94);
    checkOutput("and_sb_empty", sbq.size(), 0);

    // OR DUT: 01 and 10 mismatch.
    doClear();
    applyStimulus(2'b00, 1'b0, 100);
    applyStimulus(2'b01, 1'b1, 100);
    applyStimulus(2'b10, 1'b1, 100);
    applyStimulus(2'b11, 1'b1, 100);
    checkOutput("or_err", err_cnt, 2);
    checkOutput("or_cov", cov, 4'b1111);
    checkOutput("or_done_pass", {done, pass}, 2'b10);
    checkOutput("or_sb_empty", sbq.size(), 0);

    // Short 01 is never sampled.
    doClear();
    applyStimulus(2'b01, 1'b1, 3);
    applyStimulus(2'b10, 1'b1, 100);
    checkOutput("short_cov", cov, 4'b0100);
    checkOutput("short_err", err_cnt, 1);
    checkOutput("short_last", last_idx, 2'b10);
    checkOutput("short_sb_empty", sbq.size(), 0);

    // y stuck at 1: five mismatches, 2-bit counter saturates.
    doClear();
    applyStimulus(2'b00, 1'b1, 10);
    applyStimulus(2'b01, 1'b1, 10);
    applyStimulus(2'b10, 1'b1, 10);
    applyStimulus(2'b00, 1'b1, 10);
    applyStimulus(2'b01, 1'b1, 10);
    checkOutput("sat_err2", err_cnt2, 3);
    checkOutput("sat_pulses2", mm2_cnt, 5);
    checkOutput("sat_err", err_cnt, 5);
    checkOutput("sat_sb_empty", sbq.size(), 0);

    // Async reset in the middle of a settle count.
    doClear();
    applyStimulus(2'b00, 1'b0, 10);
    applyStimulus(2'b01, 1'b0, 10);
    checkOutput("prerst_cov", cov, 4'b0011);
    applyStimulus(2'b10, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cov", cov, 0);
    checkOutput("midrst_rest", {err_cnt, mismatch, last_idx, done, pass}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    holdFor(4);
    checkOutput("postrst_cov_early", cov, 0);
    holdFor(1);
    checkOutput("postrst_cov", cov, 4'b0100);

    // clr coincident with the 11 sample edge.
    a = 1'b1; b = 1'b1; y = 1'b0; prev_ab = 2'b11;
    holdFor(SETTLE);
    doClear();
    checkOutput("clrhit_cov", cov, 0);
    checkOutput("clrhit_err", err_cnt, 0);
    checkOutput("clrhit_mm", mismatch, 0);
    begin
      exp_t e;
      e.cyc = cyc + SETTLE;
      e.idx = 2'b11;
      sbq.push_back(e);
    end
    holdFor(SETTLE - 1);
    checkOutput("clrhit_cov_early", cov, 0);
    holdFor(1);
    checkOutput("clrhit_cov_after", cov, 4'b1000);
    checkOutput("clrhit_err_after", err_cnt, 1);
    holdFor(1);
    checkOutput("final_sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
